// File: rtl/cpu_wb_master.sv
// CPU memory/IO port to Wishbone classic master bridge.
// Each CPU access becomes one Wishbone cycle; cycles with no ACK are aborted after TIMEOUT strobe cycles.
module cpu_wb_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output logic [1:0]  state_dbg
);

  // Handshake: cpu_req is a level held until cpu_ready, which strobes for exactly one
  // cycle; m_stb_o is held with stable address/data until m_ack_i or the timeout.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign timeout_hit      = (cnt == CW'(TIMEOUT - 1));
  assign state_dbg        = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_stb_o   = 1'b0;
    cpu_ready = 1'b0;
    case (state)
      IDLE: if (cpu_req) state_nxt = BUS;
      BUS: begin
        m_stb_o = 1'b1;
        // ACK wins over a simultaneous timeout
        if (m_ack_i)          state_nxt = DONE;
        else if (timeout_hit) state_nxt = ERR;
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cpu_req) begin
            m_adr_o <= {cpu_addr[31:2], 2'b00};
            m_dat_o <= cpu_wdata;
            m_we_o  <= cpu_we;
            m_sel_o <= 4'hF;
          end
        end
        BUS: begin
          if (m_ack_i) begin
            if (!m_we_o) cpu_rdata <= m_dat_i;
          end else if (timeout_hit) begin
            // Error results are loaded here so they are valid during the ERR ready strobe
            if (!m_we_o) cpu_rdata <= ERR_DATA;
            bus_err  <= 1'b1;
            err_addr <= m_adr_o;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_wb_master.sv
// Randomized scoreboard bench for cpu_wb_master with a behavioural Wishbone slave.
module tb_cpu_wb_master;

  localparam int          TO  = 8;
  localparam logic [31:0] ERD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_stb_o;
  logic        m_ack_i = 1'b0;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [1:0]  state_dbg;

  cpu_wb_master #(.TIMEOUT(TO), .ERR_DATA(ERD)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .bus_err(bus_err),
    .err_addr(err_addr), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
    logic [31:0] cyc;
  } exp_t;

  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];
  int           stb_q[$];
  int           checks = 0;
  int           errors = 0;

  // Reference model of CPU-visible state
  logic [31:0] ref_rdata = '0;
  logic        ref_err   = 1'b0;
  logic [31:0] ref_eaddr = '0;
  int          last_ready = -10;

  // Expected bus phase of the current access and slave behaviour
  logic [31:0] exp_adr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;
  int          slv_waits = 0;
  logic [31:0] slv_data = '0;
  logic        stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- Wishbone slave model ----------------
  int slv_cnt = 0;
  always @(negedge clk) begin
    if (m_stb_o) begin
      slv_cnt = slv_cnt + 1;
      m_ack_i = (slv_cnt == slv_waits + 1);
      m_dat_i = slv_data;
    end else begin
      slv_cnt = 0;
      m_ack_i = stray_ack;
      m_dat_i = stray_ack ? ~slv_data : slv_data;
    end
  end

  // ---------------- monitor ----------------
  int   run_len = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (m_stb_o) begin
      run_len = run_len + 1;
      check("m_adr_o", m_adr_o, exp_adr);
      check("m_we_o", 32'(m_we_o), 32'(exp_we));
      check("m_sel_o", 32'(m_sel_o), 32'h0000_000F);
      if (exp_we) check("m_dat_o", m_dat_o, exp_wdata);
    end else if (run_len > 0) begin
      if (stb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL stb_run: got unexpected strobe run of %0d cycles expected none", run_len);
      end else begin
        check("stb_len", 32'(run_len), 32'(stb_q.pop_front()));
      end
      run_len = 0;
    end
    if (cpu_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got cpu_ready=1 expected 0");
      end else begin
        mon_e = exp_t'(exp_q.pop_front());
        check("cpu_rdata", cpu_rdata, mon_e.rdata);
        check("bus_err", 32'(bus_err), 32'(mon_e.err));
        check("err_addr", err_addr, mon_e.eaddr);
        check("ready_cycle", 32'(cyc), mon_e.cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // waits >= TO means the slave never acknowledges within the timeout window.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] sdata, input int waits);
    exp_t e;
    bit   acked, got;
    int   stbs, start;
    acked = (waits < TO);
    stbs  = acked ? waits + 1 : TO;
    // The request is taken at the first edge where the bridge is idle again
    start = (cyc + 1 > last_ready + 2) ? cyc + 1 : last_ready + 2;
    if (!we) ref_rdata = acked ? sdata : ERD;
    if (!acked) begin
      ref_err   = 1'b1;
      ref_eaddr = {addr[31:2], 2'b00};
    end
    e.rdata = ref_rdata; e.err = ref_err; e.eaddr = ref_eaddr; e.cyc = 32'(start + stbs);
    exp_q.push_back(W'(e));
    stb_q.push_back(stbs);
    exp_adr = {addr[31:2], 2'b00}; exp_we = we; exp_wdata = wdata;
    slv_waits = waits; slv_data = sdata;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        got = 1;
        break;
      end
    end
    if (got) last_ready = cyc;
    else begin
      checks++; errors++;
      $display("FAIL ready_wait: got no cpu_ready within 300 cycles expected one");
      cpu_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stb"}, 32'(m_stb_o), 32'h0);
    check({tag, "_ready"}, 32'(cpu_ready), 32'h0);
    check({tag, "_adr"}, m_adr_o, 32'h0);
    check({tag, "_dat"}, m_dat_o, 32'h0);
    check({tag, "_we"}, 32'(m_we_o), 32'h0);
    check({tag, "_sel"}, 32'(m_sel_o), 32'h0);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    check({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  task automatic reset_mid_bus(input logic [31:0] addr);
    bit seen;
    stb_q.push_back(2);
    exp_adr = {addr[31:2], 2'b00}; exp_we = 1'b0;
    slv_waits = 1000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (m_stb_o) begin
        seen = 1;
        break;
      end
    end
    check("rst_stb_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    ref_rdata = '0; ref_err = 1'b0; ref_eaddr = '0; last_ready = -10;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, waits;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // single read, ACK in first strobe cycle
    access(1'b0, 32'h0000_0106, 32'h0, 32'h1234_5678, 0);
    idle(1);
    // write with three wait states
    access(1'b1, 32'hFFFF_FF00, 32'hA5A5_0F0F, 32'h0BAD_0BAD, 3);
    idle(2);
    // ACK on the last timeout cycle
    access(1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, TO - 1);
    idle(1);
    // unmapped read times out, then a good read keeps bus_err
    access(1'b0, 32'h8000_0000, 32'h0, 32'h1111_2222, 1000);
    idle(1);
    access(1'b0, 32'h0000_0040, 32'h0, 32'h3333_4444, 0);
    idle(1);
    // back-to-back with cpu_req held, stray ACK outside strobe
    access(1'b0, 32'h0000_1000, 32'h0, 32'h5555_6666, 0);
    stray_ack = 1'b1;
    access(1'b0, 32'h0000_1004, 32'h0, 32'h7777_8888, 1);
    idle(3);
    stray_ack = 1'b0;
    check("stray_rdata", cpu_rdata, ref_rdata);
    check("stray_stb", 32'(m_stb_o), 32'h0);

    // randomized phase
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      waits = (r < 6) ? (r % 4) : r;
      access(1'(($urandom_range(0, 1))), $urandom, $urandom, $urandom, waits);
      r = $urandom_range(0, 2);
      if (r > 0) idle(r);
    end
    idle(1);

    reset_mid_bus(32'h0000_2008);
    access(1'b0, 32'h0000_0300, 32'h0, 32'h9999_AAAA, 2);
    idle(4);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("stb_q_empty", 32'(stb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
